// File: rtl/knn_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : knn_seq_ctrl_pkg
// Brief    : Shared state encodings and parameter defaults for the KNN sequencer
// Revision : 1.0
// ============================================================================
package knn_seq_ctrl_pkg;

   localparam int c_data_w  = 32;
   localparam int c_dist_w  = 2 * c_data_w;
   localparam int c_label_w = 8;
   localparam int c_k       = 10;
   localparam int c_cnt_w   = 16;

   localparam int c_state_w = 3;
   localparam logic [c_state_w-1:0] c_st_idle   = 3'd0;
   localparam logic [c_state_w-1:0] c_st_load   = 3'd1;
   localparam logic [c_state_w-1:0] c_st_calc   = 3'd2;
   localparam logic [c_state_w-1:0] c_st_insert = 3'd3;
   localparam logic [c_state_w-1:0] c_st_done   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/knn_topk_list.sv
`default_nettype none
// ============================================================================
// Module   : knn_topk_list
// Brief    : K-entry sorted nearest-neighbour list, single-cycle insert + read mux
// Revision : 1.0
// ============================================================================
module knn_topk_list
   import knn_seq_ctrl_pkg::*;
#(
   parameter int K       = c_k,
   parameter int DIST_W  = c_dist_w,
   parameter int LABEL_W = c_label_w,
   parameter int IDX_W   = $clog2(K),
   parameter int NV_W    = $clog2(K+1)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               ins,
   input  logic [DIST_W-1:0]  ins_dist,
   input  logic [LABEL_W-1:0] ins_label,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic [NV_W-1:0]    n_valid,
   output logic [DIST_W-1:0]  rd_dist,
   output logic [LABEL_W-1:0] rd_label
);

   logic [DIST_W-1:0]  r_dist  [K];
   logic [LABEL_W-1:0] r_label [K];
   logic               r_vld   [K];
   logic [NV_W-1:0]    r_nv;

   logic [DIST_W-1:0]  w_nx_dist  [K];
   logic [LABEL_W-1:0] w_nx_label [K];
   logic               w_nx_vld   [K];
   logic [K:0]         w_le_ext;
   logic [DIST_W-1:0]  w_pv_dist  [K];
   logic [LABEL_W-1:0] w_pv_label [K];
   logic               w_pv_vld   [K];

   // Valid entries form a sorted prefix, so the "dist <= new" flags are a run of
   // ones; the new entry lands where that run ends and everything after shifts down.
   always_comb begin
      w_le_ext[0] = 1'b1;
      for (int i = 0; i < K; i++) begin
         w_le_ext[i+1] = r_vld[i] && (r_dist[i] <= ins_dist);
      end
      w_pv_dist[0]  = '0;
      w_pv_label[0] = '0;
      w_pv_vld[0]   = 1'b0;
      for (int i = 1; i < K; i++) begin
         w_pv_dist[i]  = r_dist[i-1];
         w_pv_label[i] = r_label[i-1];
         w_pv_vld[i]   = r_vld[i-1];
      end
      for (int i = 0; i < K; i++) begin
         w_nx_dist[i]  = r_dist[i];
         w_nx_label[i] = r_label[i];
         w_nx_vld[i]   = r_vld[i];
         if (!w_le_ext[i+1]) begin
            if (w_le_ext[i]) begin
               w_nx_dist[i]  = ins_dist;
               w_nx_label[i] = ins_label;
               w_nx_vld[i]   = 1'b1;
            end else begin
               w_nx_dist[i]  = w_pv_dist[i];
               w_nx_label[i] = w_pv_label[i];
               w_nx_vld[i]   = w_pv_vld[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < K; i++) begin
            r_dist[i]  <= '0;
            r_label[i] <= '0;
            r_vld[i]   <= 1'b0;
         end
         r_nv <= '0;
      end else if (clr) begin
         for (int i = 0; i < K; i++) begin
            r_dist[i]  <= '0;
            r_label[i] <= '0;
            r_vld[i]   <= 1'b0;
         end
         r_nv <= '0;
      end else if (ins) begin
         for (int i = 0; i < K; i++) begin
            r_dist[i]  <= w_nx_dist[i];
            r_label[i] <= w_nx_label[i];
            r_vld[i]   <= w_nx_vld[i];
         end
         if (r_nv != NV_W'(K)) begin
            r_nv <= r_nv + 1'b1;
         end
      end
   end

   // Unoccupied slots and out-of-range indices never match, so they read as zero.
   always_comb begin
      rd_dist  = '0;
      rd_label = '0;
      for (int i = 0; i < K; i++) begin
         if ((IDX_W'(i) == rd_idx) && r_vld[i]) begin
            rd_dist  = r_dist[i];
            rd_label = r_label[i];
         end
      end
   end

   assign n_valid = r_nv;

endmodule
`default_nettype wire

// File: rtl/knn_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : knn_seq_ctrl
// Brief    : KNN sequencer: streams training points through knn_core, keeps top-K
// Revision : 1.0
// ============================================================================
module knn_seq_ctrl
   import knn_seq_ctrl_pkg::*;
#(
   parameter int DATA_W  = c_data_w,
   parameter int DIST_W  = c_dist_w,
   parameter int LABEL_W = c_label_w,
   parameter int K       = c_k,
   parameter int CNT_W   = c_cnt_w
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   soft_clr,
   input  logic                   start,
   input  logic [DATA_W-1:0]      test_x,
   input  logic [DATA_W-1:0]      test_y,
   input  logic                   pt_valid,
   output logic                   pt_ready,
   input  logic [DATA_W-1:0]      pt_x,
   input  logic [DATA_W-1:0]      pt_y,
   input  logic [LABEL_W-1:0]     pt_label,
   input  logic                   pt_last,
   output logic                   core_start,
   output logic [DATA_W-1:0]      core_x1,
   output logic [DATA_W-1:0]      core_y1,
   output logic [DATA_W-1:0]      core_x2,
   output logic [DATA_W-1:0]      core_y2,
   input  logic                   core_done,
   input  logic [DIST_W-1:0]      core_z,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       n_pts,
   output logic [$clog2(K+1)-1:0] n_valid,
   input  logic [$clog2(K)-1:0]   rd_idx,
   output logic [DIST_W-1:0]      rd_dist,
   output logic [LABEL_W-1:0]     rd_label
);

   localparam logic [CNT_W-1:0] c_npts_max = {CNT_W{1'b1}};

   logic [c_state_w-1:0] r_state;
   logic [c_state_w-1:0] w_next;
   logic                 w_start_ok;
   logic                 w_accept;
   logic [DATA_W-1:0]    r_tx, r_ty, r_px, r_py;
   logic [LABEL_W-1:0]   r_label;
   logic                 r_last;
   logic [DIST_W-1:0]    r_dist;
   logic [CNT_W-1:0]     r_npts;
   logic                 r_core_start;

   assign w_start_ok = start && ((r_state == c_st_idle) || (r_state == c_st_done));
   assign w_accept   = (r_state == c_st_load) && pt_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_st_idle;
      end else if (soft_clr) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_st_idle:   if (start) w_next = c_st_load;
         c_st_load:   if (pt_valid) w_next = c_st_calc;
         c_st_calc:   if (core_done) w_next = c_st_insert;
         c_st_insert: w_next = r_last ? c_st_done : c_st_load;
         c_st_done:   if (start) w_next = c_st_load;
         default:     w_next = c_st_idle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx         <= '0;
         r_ty         <= '0;
         r_px         <= '0;
         r_py         <= '0;
         r_label      <= '0;
         r_last       <= 1'b0;
         r_dist       <= '0;
         r_npts       <= '0;
         r_core_start <= 1'b0;
      end else if (soft_clr) begin
         r_tx         <= '0;
         r_ty         <= '0;
         r_px         <= '0;
         r_py         <= '0;
         r_label      <= '0;
         r_last       <= 1'b0;
         r_dist       <= '0;
         r_npts       <= '0;
         r_core_start <= 1'b0;
      end else begin
         // Registered so the pulse lands on exactly the first CALC cycle.
         r_core_start <= w_accept;
         if (w_start_ok) begin
            r_tx   <= test_x;
            r_ty   <= test_y;
            r_npts <= '0;
         end
         if (w_accept) begin
            r_px    <= pt_x;
            r_py    <= pt_y;
            r_label <= pt_label;
            r_last  <= pt_last;
         end
         if ((r_state == c_st_calc) && core_done) begin
            r_dist <= core_z;
         end
         if ((r_state == c_st_insert) && (r_npts != c_npts_max)) begin
            r_npts <= r_npts + 1'b1;
         end
      end
   end

   always_comb begin
      pt_ready   = (r_state == c_st_load);
      busy       = (r_state != c_st_idle) && (r_state != c_st_done);
      done       = (r_state == c_st_done);
      core_start = r_core_start;
      core_x1    = r_tx;
      core_y1    = r_ty;
      core_x2    = r_px;
      core_y2    = r_py;
      n_pts      = r_npts;
   end

   knn_topk_list #(
      .K       (K),
      .DIST_W  (DIST_W),
      .LABEL_W (LABEL_W)
   ) u_list (
      .clk       (clk),
      .rst       (rst),
      .clr       (soft_clr || w_start_ok),
      .ins       (r_state == c_st_insert),
      .ins_dist  (r_dist),
      .ins_label (r_label),
      .rd_idx    (rd_idx),
      .n_valid   (n_valid),
      .rd_dist   (rd_dist),
      .rd_label  (rd_label)
   );

endmodule
`default_nettype wire

// File: tb/tb_knn_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_knn_seq_ctrl
// Brief    : Self-checking bench for knn_seq_ctrl with a stub squared-distance core
// Revision : 1.0
// ============================================================================
module tb_knn_seq_ctrl;

   localparam int DATA_W  = 32;
   localparam int DIST_W  = 64;
   localparam int LABEL_W = 8;
   localparam int K       = 4;
   localparam int CNT_W   = 3;
   localparam int IDX_W   = $clog2(K);
   localparam int NV_W    = $clog2(K+1);
   localparam int NPTS_MAX = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               soft_clr = 1'b0;
   logic               start = 1'b0;
   logic [DATA_W-1:0]  test_x = '0, test_y = '0;
   logic               pt_valid = 1'b0;
   logic               pt_ready;
   logic [DATA_W-1:0]  pt_x = '0, pt_y = '0;
   logic [LABEL_W-1:0] pt_label = '0;
   logic               pt_last = 1'b0;
   logic               core_start;
   logic [DATA_W-1:0]  core_x1, core_y1, core_x2, core_y2;
   logic               core_done;
   logic [DIST_W-1:0]  core_z;
   logic               busy, done;
   logic [CNT_W-1:0]   n_pts;
   logic [NV_W-1:0]    n_valid;
   logic [IDX_W-1:0]   rd_idx = '0;
   logic [DIST_W-1:0]  rd_dist;
   logic [LABEL_W-1:0] rd_label;

   typedef struct {
      longint unsigned d;
      int unsigned     l;
   } ent_t;

   typedef struct {
      int unsigned x, y, lbl;
      bit          last;
      int unsigned nv, d0, l0;
   } vec_t;

   int   n_err = 0;
   int   n_checks = 0;
   ent_t acc_q[$];
   int unsigned tx = 0, ty = 0;

   // stub core state
   int                lat = 1;
   int                cd = 0;
   logic              stub_done = 1'b0;
   logic [DIST_W-1:0] stub_z = '0;
   logic              stray = 1'b0;
   logic [DIST_W-1:0] stray_z = '0;

   // handshake monitor
   bit mon_en = 1'b0;
   int cs_cnt = 0;
   int hs_bad = 0;
   bit prev_done = 1'b0;

   assign core_done = stub_done | stray;
   assign core_z    = stray ? stray_z : stub_z;

   always #5 clk = ~clk;

   knn_seq_ctrl #(
      .DATA_W (DATA_W), .DIST_W (DIST_W), .LABEL_W (LABEL_W), .K (K), .CNT_W (CNT_W)
   ) u_dut (
      .clk (clk), .rst (rst), .soft_clr (soft_clr), .start (start),
      .test_x (test_x), .test_y (test_y),
      .pt_valid (pt_valid), .pt_ready (pt_ready),
      .pt_x (pt_x), .pt_y (pt_y), .pt_label (pt_label), .pt_last (pt_last),
      .core_start (core_start),
      .core_x1 (core_x1), .core_y1 (core_y1), .core_x2 (core_x2), .core_y2 (core_y2),
      .core_done (core_done), .core_z (core_z),
      .busy (busy), .done (done), .n_pts (n_pts), .n_valid (n_valid),
      .rd_idx (rd_idx), .rd_dist (rd_dist), .rd_label (rd_label)
   );

   function automatic longint unsigned sqd(input longint unsigned ax, ay, bx, by);
      longint unsigned dx, dy;
      dx = (ax > bx) ? ax - bx : bx - ax;
      dy = (ay > by) ? ay - by : by - ay;
      return dx * dx + dy * dy;
   endfunction

   always @(posedge clk) begin
      stub_done <= 1'b0;
      if (core_start) begin
         cd <= lat;
      end else if (cd != 0) begin
         cd <= cd - 1;
         if (cd == 1) begin
            stub_done <= 1'b1;
            stub_z    <= DIST_W'(sqd(64'(core_x1), 64'(core_y1), 64'(core_x2), 64'(core_y2)));
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (core_start) cs_cnt++;
         if (pt_ready && (core_start || cd != 0 || stub_done || prev_done)) hs_bad++;
      end
      prev_done = stub_done;
   end

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_start(input int unsigned x, input int unsigned y);
      @(negedge clk);
      test_x = DATA_W'(x);
      test_y = DATA_W'(y);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      acc_q.delete();
      tx = x;
      ty = y;
   endtask

   task automatic send_pt(input int unsigned x, y, l, input bit last, input bit hold);
      int t = 0;
      @(negedge clk);
      pt_x = DATA_W'(x); pt_y = DATA_W'(y); pt_label = LABEL_W'(l); pt_last = last;
      pt_valid = 1'b1;
      while (!pt_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!pt_ready) begin
         chk("pt_ready timeout", 0, 1);
      end else begin
         @(posedge clk);
         #1;
         acc_q.push_back('{sqd(64'(tx), 64'(ty), 64'(x), 64'(y)), l});
      end
      if (!hold) pt_valid = 1'b0;
   endtask

   task automatic wait_ready_or_done();
      int t = 0;
      @(negedge clk);
      while (!(pt_ready || done) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!(pt_ready || done)) chk("ready/done timeout", 0, 1);
   endtask

   task automatic wait_done();
      int t = 0;
      @(negedge clk);
      while (!done && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("done reached", done, 1);
   endtask

   // Expected list: stable sort of every accepted point by distance, first K kept.
   task automatic check_list(input string tag);
      ent_t s[$];
      ent_t tmp;
      longint unsigned ed, el;
      s = acc_q;
      for (int a = 0; a < s.size(); a++)
         for (int b = 0; b < s.size() - 1 - a; b++)
            if (s[b].d > s[b+1].d) begin
               tmp = s[b]; s[b] = s[b+1]; s[b+1] = tmp;
            end
      chk($sformatf("%s n_valid", tag), n_valid, (s.size() < K) ? s.size() : K);
      for (int i = 0; i < K; i++) begin
         rd_idx = IDX_W'(i);
         #1;
         ed = (i < s.size()) ? s[i].d : 0;
         el = (i < s.size()) ? s[i].l : 0;
         chk($sformatf("%s rd_dist[%0d]", tag, i), rd_dist, ed);
         chk($sformatf("%s rd_label[%0d]", tag, i), rd_label, el);
      end
   endtask

   vec_t        tbl[5];
   int unsigned fin_d[4];
   int unsigned fin_l[4];

   initial begin
      tbl[0] = '{3, 4, 1, 1'b0, 1, 25, 1};
      tbl[1] = '{1, 1, 2, 1'b0, 2, 2, 2};
      tbl[2] = '{10, 0, 3, 1'b0, 3, 2, 2};
      tbl[3] = '{2, 2, 4, 1'b0, 4, 2, 2};
      tbl[4] = '{0, 1, 5, 1'b1, 4, 1, 5};
      fin_d = '{1, 2, 8, 25};
      fin_l = '{5, 2, 4, 1};

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst pt_ready", pt_ready, 0);
      chk("rst n_valid", n_valid, 0);

      // Reset mid-CALC
      lat = 7;
      do_start(2, 2);
      send_pt(5, 5, 3, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("pre-reset busy", busy, 1);
      rst = 1'b0;
      #1;
      chk("async rst busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid rst busy", busy, 0);
      chk("mid rst done", done, 0);
      chk("mid rst n_valid", n_valid, 0);
      chk("mid rst n_pts", n_pts, 0);
      chk("mid rst core_start", core_start, 0);
      chk("mid rst pt_ready", pt_ready, 0);
      chk("mid rst core_x2", core_x2, 0);
      repeat (12) @(negedge clk);

      // Sort table, 1-cycle core
      lat = 1;
      do_start(0, 0);
      for (int i = 0; i < 5; i++) begin
         send_pt(tbl[i].x, tbl[i].y, tbl[i].lbl, tbl[i].last, 1'b0);
         wait_ready_or_done();
         rd_idx = '0;
         #1;
         chk($sformatf("sort[%0d] n_valid", i), n_valid, tbl[i].nv);
         chk($sformatf("sort[%0d] rd_dist0", i), rd_dist, tbl[i].d0);
         chk($sformatf("sort[%0d] rd_label0", i), rd_label, tbl[i].l0);
      end
      chk("sort done", done, 1);
      chk("sort n_pts", n_pts, 5);
      for (int i = 0; i < 4; i++) begin
         rd_idx = IDX_W'(i);
         #1;
         chk($sformatf("sort fin dist[%0d]", i), rd_dist, fin_d[i]);
         chk($sformatf("sort fin label[%0d]", i), rd_label, fin_l[i]);
      end

      // Ties and drop: all distance 9
      do_start(5, 5);
      send_pt(8, 5, 1, 1'b0, 1'b0);
      send_pt(2, 5, 2, 1'b0, 1'b0);
      send_pt(5, 8, 3, 1'b0, 1'b0);
      send_pt(5, 2, 4, 1'b0, 1'b0);
      send_pt(8, 5, 5, 1'b0, 1'b0);
      send_pt(2, 5, 6, 1'b1, 1'b0);
      wait_done();
      chk("ties n_pts", n_pts, 6);
      check_list("ties");

      // Underfill
      do_start(0, 0);
      send_pt(1, 2, 7, 1'b0, 1'b0);
      send_pt(1, 1, 8, 1'b1, 1'b0);
      wait_done();
      check_list("underfill");

      // start during LOAD is ignored
      do_start(100, 100);
      send_pt(100, 103, 9, 1'b0, 1'b0);
      wait_ready_or_done();
      @(negedge clk);
      test_x = '0; test_y = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_pt(100, 101, 10, 1'b1, 1'b0);
      wait_done();
      chk("ignored start n_pts", n_pts, 2);
      check_list("ignored start");

      // Restart after DONE
      do_start(0, 0);
      send_pt(3, 0, 11, 1'b1, 1'b0);
      wait_done();
      chk("restart n_pts", n_pts, 1);
      check_list("restart");

      // Handshake: 7-cycle core, pt_valid held, stray core_done in LOAD
      lat = 7;
      do_start(1, 1);
      @(negedge clk);
      stray_z = 64'd3; stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      @(negedge clk);
      chk("stray n_valid", n_valid, 0);
      chk("stray pt_ready", pt_ready, 1);
      cs_cnt = 0; hs_bad = 0; mon_en = 1'b1;
      send_pt(4, 1, 21, 1'b0, 1'b1);
      send_pt(1, 2, 22, 1'b0, 1'b1);
      send_pt(0, 0, 23, 1'b0, 1'b1);
      send_pt(9, 9, 24, 1'b0, 1'b1);
      send_pt(1, 3, 25, 1'b1, 1'b1);
      pt_valid = 1'b0;
      wait_done();
      mon_en = 1'b0;
      chk("hs core_start count", cs_cnt, 5);
      chk("hs ready violations", hs_bad, 0);
      check_list("handshake");

      // Randomized runs, including n_pts saturation
      for (int r = 0; r < 12; r++) begin
         int n;
         lat = $urandom_range(1, 4);
         do_start($urandom_range(0, 7), $urandom_range(0, 7));
         n = (r == 0) ? 10 : $urandom_range(1, 10);
         for (int p = 0; p < n; p++) begin
            send_pt($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 255),
                    (p == n - 1), 1'($urandom_range(0, 1)));
         end
         pt_valid = 1'b0;
         wait_done();
         chk($sformatf("rand%0d n_pts", r), n_pts, (n > NPTS_MAX) ? NPTS_MAX : n);
         check_list($sformatf("rand%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/knn_seq_ctrl.md
Name: knn_seq_ctrl

Overview:
Sequencer for the KNN distance core inside the iob_knn peripheral.
- Accepts one test point and a stream of labelled training points.
- Drives each training point through the distance core.
- Keeps a sorted list of the K nearest neighbours in hardware, replacing the software bubble sort.
- Sits between the peripheral's register file and knn_core. Results are read back by index.

Parameters:
DATA_W, 32, coordinate width (unsigned)
DIST_W, 64, distance result width from knn_core (2*DATA_W)
LABEL_W, 8, class label width
K, 10, number of nearest neighbours kept (2..16)
CNT_W, 16, training-point counter width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
soft_clr  in  1  synchronous clear (KNN_RESET); same effect as rst
start  in  1  one-cycle pulse: latch test_x/test_y, clear list, enter LOAD
test_x  in  DATA_W  test point x
test_y  in  DATA_W  test point y
pt_valid  in  1  training point valid
pt_ready  out  1  controller accepts point (high only in LOAD)
pt_x  in  DATA_W  training point x
pt_y  in  DATA_W  training point y
pt_label  in  LABEL_W  training point label
pt_last  in  1  marks final training point
core_start  out  1  one-cycle pulse to distance core
core_x1  out  DATA_W  test x (registered)
core_y1  out  DATA_W  test y (registered)
core_x2  out  DATA_W  training x (registered)
core_y2  out  DATA_W  training y (registered)
core_done  in  1  distance valid pulse
core_z  in  DIST_W  distance
busy  out  1  high from start to DONE
done  out  1  level, high in DONE state
n_pts  out  CNT_W  training points processed (saturating)
n_valid  out  $clog2(K+1)  occupied list entries
rd_idx  in  $clog2(K)  read index, 0 = nearest
rd_dist  out  DIST_W  distance at rd_idx (combinational read)
rd_label  out  LABEL_W  label at rd_idx

Behaviour:
- Reset (rst low, async) or soft_clr (sync):
  - State returns to IDLE.
  - All list valid bits, n_pts, busy, done, core_start and pt_ready go to 0.
  - All registered coords go to 0.
  - Reset mid-operation aborts with no residue.
- States:
  - IDLE: waits for start.
  - LOAD: pt_ready=1; on pt_valid&pt_ready, register the point and pt_last, go to CALC.
  - CALC: core_start pulses on the first cycle only. Wait for core_done, then register core_z and go to INSERT.
  - INSERT: one cycle. Then go to DONE if last was set, else back to LOAD.
  - DONE: done=1 and busy=0. start re-enters LOAD with a cleared list. No other exit.
- start is ignored outside IDLE/DONE.
- core_done outside CALC is ignored.
- Insertion, single cycle, parallel compare:
  - Invalid entries compare as +infinity.
  - New entry goes at position p = number of valid entries with dist <= new dist. Ties are stable: the new entry goes after equal entries.
  - Entries p..K-2 shift down by one and entry K-1 is dropped.
  - If p == K, the list is unchanged.
  - n_valid increments up to K.
- n_pts increments in INSERT and saturates at 2^CNT_W-1.
- Throughput: 1 (accept) + core latency + 1 (insert) cycles per point. Minimum 3 cycles with a 1-cycle core.
- rd_dist/rd_label:
  - For rd_idx >= n_valid, return 0.
  - rd_idx >= K returns 0.
- pt_last with no further points: list holds whatever was accepted. A zero-point run cannot occur because at least one point is needed to reach DONE.

Decomposition:
- Shared package/header: state encodings (IDLE, LOAD, CALC, INSERT, DONE), K, DIST_W, LABEL_W defaults. These go in iob_knn.vh alongside the existing KNN defines.
- One natural sub-module: knn_topk_list. It holds the K-entry sorted insert/shift register array with valid bits, the parallel comparator, and the read mux.
- knn_seq_ctrl keeps the FSM, counters and core handshake.

Test Plan:
- Reset/idle: hold rst low mid-CALC, release -> state IDLE, busy=0, done=0, n_valid=0, core_start=0, pt_ready=0.
- Sort, K=4, test (0,0), 1-cycle stub core computing squared distance:
  - Stimulus: points (3,4,L1),(1,1,L2),(10,0,L3),(2,2,L4),(0,1,L5,last).
  - Required: done=1, n_pts=5, n_valid=4; rd 0..3 = (1,L5),(2,L2),(8,L4),(25,L1).
- Ties and drop, K=4: six points all with distance 9, labels 1..6 -> list labels 1,2,3,4 (stable order); labels 5 and 6 dropped.
- Underfill, K=10: two points with distances 5 then 2 -> n_valid=2, rd0=2, rd1=5, rd_idx=5 returns 0.
- Handshake:
  - Stimulus: core latency 7 cycles, pt_valid held continuously.
  - Required: pt_ready low during CALC/INSERT; exactly one core_start per point.
  - Stimulus: stray core_done pulse in LOAD -> list unchanged.
- Restart: after DONE, pulse start with new test point, stream 1 point (last) -> n_valid=1, n_pts=1, old entries gone. start pulsed during LOAD -> ignored.
